// File: rtl/slow_mult_collector_pkg.sv
// Shared constants for the slow multiplier and its result collector.
// Both blocks pick up their default operand width, Q-format fraction and
// output queue depth from here so they stay in step.
package slow_mult_collector_pkg;

    localparam int DEFAULT_SIZE  = 16;
    localparam int DEFAULT_FRAC  = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Bits needed to hold any value in 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/slow_mult_collector_sync_fifo.sv
// Small synchronous FIFO holding rounded results until the consumer takes them.
// Head data is read combinationally so it is valid whenever the FIFO is not
// empty. A push into a full FIFO is accepted only when a pop happens in the
// same cycle; a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int width = 17,
    parameter int depth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             din,
    output logic [width-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int AW = $clog2(depth);
    localparam int CW = $clog2(depth + 1);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(depth));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/slow_mult_collector.sv
// Collector that sits beside a pipelined slow multiplier: it tracks which
// pipeline slots carry real operands, captures each finished product once,
// rounds/saturates it to a Q-format result and queues it for a consumer.
// Issue is throttled so queued plus in-flight results never exceed the queue.
module slow_mult_collector
    import slow_mult_collector_pkg::*;
#(
    parameter int size  = DEFAULT_SIZE,
    parameter int frac  = DEFAULT_FRAC,
    parameter int depth = DEFAULT_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                in_valid,
    input  logic [2*size-1:0]   product,
    output logic                can_issue,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [size-1:0]     out_data,
    output logic                sat,
    output logic                drop_err
);

    localparam int PW  = 2 * size;
    localparam int TAP = (size > 1) ? size - 2 : size - 1;
    localparam int IW  = cnt_width(size + 1);
    localparam int CW  = cnt_width(depth);
    localparam int SW  = ((IW > CW) ? IW : CW) + 1;
    localparam int RSH = (frac > 0) ? frac - 1 : 0;
    localparam logic [PW:0] ROUND = (frac > 0) ? ((PW + 1)'(1) << RSH) : '0;

    logic [size-1:0] vpipe_reg;
    logic [size-1:0] vpipe_next;
    logic            new_prod_reg;
    logic            new_prod_next;
    logic [IW-1:0]   inflight_reg;
    logic [IW-1:0]   inflight_next;
    logic            drop_err_reg;
    logic            drop_err_next;

    logic            issue;
    logic            shift_out;
    logic [PW:0]     rounded;
    logic            res_sat;
    logic [size-1:0] res_data;

    logic            push;
    logic            pop;
    logic [size:0]   fifo_din;
    logic [size:0]   fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

    assign issue     = enable & in_valid;
    assign shift_out = enable & vpipe_reg[size-1];

    // Valid-tracking shift register: each bit advances only on enabled edges.
    genvar gi;
    generate
        for (gi = 0; gi < size; gi++) begin : g_vpipe
            if (gi == 0) begin : g_head
                assign vpipe_next[gi] = enable ? in_valid : vpipe_reg[gi];
            end else begin : g_body
                assign vpipe_next[gi] = enable ? vpipe_reg[gi-1] : vpipe_reg[gi];
            end
        end
    endgenerate

    // Next-state for the fresh-product flag, in-flight counter and sticky drop flag.
    always_comb begin
        new_prod_next = enable & vpipe_reg[TAP];
        inflight_next = inflight_reg + IW'(issue) + IW'(new_prod_next)
                        - IW'(shift_out) - IW'(new_prod_reg);
        drop_err_next = drop_err_reg | (new_prod_reg & fifo_full & ~pop);
    end

    // Tracking state; reset discards every in-flight marker so nothing stale is captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vpipe_reg    <= '0;
            new_prod_reg <= 1'b0;
            inflight_reg <= '0;
            drop_err_reg <= 1'b0;
        end else begin
            vpipe_reg    <= vpipe_next;
            new_prod_reg <= new_prod_next;
            inflight_reg <= inflight_next;
            drop_err_reg <= drop_err_next;
        end
    end

    // Round half-up at one extra bit of headroom, then saturate to the output width.
    always_comb begin
        rounded  = ({1'b0, product} + ROUND) >> frac;
        res_sat  = |rounded[PW:size];
        res_data = res_sat ? '1 : rounded[size-1:0];
    end

    // Capture happens at the edge that ends the new-product cycle, independent of enable.
    assign push     = new_prod_reg;
    assign pop      = out_ready & ~fifo_empty;
    assign fifo_din = {res_sat, res_data};

    sync_fifo #(
        .width (size + 1),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign sat       = fifo_dout[size];
    assign out_data  = fifo_dout[size-1:0];
    assign drop_err  = drop_err_reg;
    assign can_issue = (SW'(fifo_count) + SW'(inflight_reg)) < SW'(depth);

endmodule

// File: tb/tb_slow_mult_collector.sv
`timescale 1ns/1ps
// Bench for slow_mult_collector paired with a behavioural 16-stage multiplier.
module tb_slow_mult_collector;

    localparam int SIZE  = 16;
    localparam int FRAC  = 8;
    localparam int DEPTH = 4;

    logic                clk;
    logic                reset;
    logic                enable;
    logic                in_valid;
    logic [2*SIZE-1:0]   product;
    logic                can_issue;
    logic                out_valid;
    logic                out_ready;
    logic [SIZE-1:0]     out_data;
    logic                sat;
    logic                drop_err;
    logic [SIZE-1:0]     op_a;
    logic [SIZE-1:0]     op_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [SIZE:0] exp_q[$];

    slow_mult_collector #(
        .size  (SIZE),
        .frac  (FRAC),
        .depth (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .product   (product),
        .can_issue (can_issue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat       (sat),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: SIZE enabled edges from operands to product.
    logic [2*SIZE-1:0] ppipe [SIZE];
    always @(posedge clk) begin
        if (enable) begin
            ppipe[0] <= op_a * op_b;
            for (int i = 1; i < SIZE; i++) ppipe[i] <= ppipe[i-1];
        end
    end
    assign product = ppipe[SIZE-1];

    // Reference result {sat, data} from plain arithmetic.
    function automatic logic [SIZE:0] ref_result(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        if (FRAC > 0) p = p + (longint'(1) << (FRAC - 1));
        p = p >> FRAC;
        if (p > longint'(2**SIZE - 1)) return {1'b1, {SIZE{1'b1}}};
        return {1'b0, p[SIZE-1:0]};
    endfunction

    function automatic logic [SIZE-1:0] pick_op();
        case ($urandom_range(0, 3))
            0:       return {SIZE{1'b1}};
            1:       return SIZE'($urandom_range(0, 255));
            default: return SIZE'($urandom);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the head against the scoreboard when it will transfer at the next edge.
    task automatic xfer_check();
        logic [SIZE:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL stale_out: got %h with no result expected", {sat, out_data});
            end else begin
                e = exp_q.pop_front();
                check("xfer", {15'd0, sat, out_data}, {15'd0, e});
                $display("xfer data=%h sat=%b", out_data, sat);
            end
        end
    endtask

    typedef struct {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE-1:0] exp_data;
        logic            exp_sat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int accepted;
        int stale;
        logic want;
        logic hold_pending;
        logic [SIZE:0] held;
        logic [SIZE:0] head_before;

        vecs[0] = '{16'h0300, 16'h0200, 16'h0600, 1'b0};
        vecs[1] = '{16'h0001, 16'h0080, 16'h0001, 1'b0};
        vecs[2] = '{16'h0001, 16'h007F, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h1000, 16'h1000, 16'hFFFF, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0100, 16'hFFFF, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0101, 16'h0100, 1'b0};
        vecs[7] = '{16'h0002, 16'h00C0, 16'h0002, 1'b0};
        vecs[8] = '{16'h0000, 16'h1234, 16'h0000, 1'b0};

        reset = 1'b0; enable = 1'b0; in_valid = 1'b0;
        op_a = '0; op_b = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        check("reset_out_valid", out_valid, 0);
        check("reset_can_issue", can_issue, 1);
        check("reset_drop_err", drop_err, 0);

        // Single issues; latency counted in edges including the issue edge.
        enable = 1'b1;
        for (int v = 0; v < 9; v++) begin
            in_valid = 1'b1; op_a = vecs[v].a; op_b = vecs[v].b;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 40) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", v), lat, 17);
            check($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
            check($sformatf("vec%0d_sat", v), sat, vecs[v].exp_sat);
            $display("vec%0d a=%h b=%h data=%h sat=%b", v, op_a, op_b, out_data, sat);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check($sformatf("vec%0d_popped", v), out_valid, 0);
            check($sformatf("vec%0d_can_issue", v), can_issue, 1);
        end

        // Fill with the consumer stalled: exactly DEPTH results accepted.
        accepted = 0;
        for (int c = 0; c < 80; c++) begin
            if (can_issue) begin
                in_valid = 1'b1; op_a = pick_op(); op_b = pick_op();
                exp_q.push_back(ref_result(op_a, op_b));
                accepted++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", accepted, DEPTH);
        check("fill_can_issue", can_issue, 0);
        check("fill_drop_err", drop_err, 0);
        check("fill_out_valid", out_valid, 1);

        // Protocol violation while full: product dropped, queue untouched.
        head_before = {sat, out_data};
        in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h5678;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("drop_err_set", drop_err, 1);
        check("drop_head_same", {sat, out_data}, head_before);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_valid", out_valid, 1);
            xfer_check();
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drop_err_sticky", drop_err, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("drop_err_cleared", drop_err, 0);

        // Reset with three results in flight: all discarded.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_a = pick_op(); op_b = pick_op();
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_can_issue", can_issue, 1);
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) stale++;
            tick();
        end
        check("midreset_no_stale", stale, 0);

        // Random enable, issue and consumer back-pressure against the scoreboard.
        hold_pending = 1'b0;
        held = '0;
        for (int c = 0; c < 1500; c++) begin
            enable    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 4) < 3);
            want      = ($urandom_range(0, 1) == 1);
            in_valid  = want && (can_issue || !enable);
            if (in_valid) begin
                op_a = pick_op(); op_b = pick_op();
                if (enable) exp_q.push_back(ref_result(op_a, op_b));
            end
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {15'd0, sat, out_data}, {15'd0, held});
            end
            xfer_check();
            hold_pending = out_valid && !out_ready;
            held = {sat, out_data};
            tick();
        end
        enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            xfer_check();
            tick();
        end
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_out_valid", out_valid, 0);
        check("rand_drop_err", drop_err, 0);
        check("rand_can_issue", can_issue, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/slow_mult_collector.md
SLOW_MULT_COLLECTOR -- requirements
Module: slow_mult_collector

Interface
REQ-001 SHALL have parameter size, default 16: operand width of the upstream slow_multiplication; its product is 2*size bits.
REQ-002 SHALL have parameter frac, default 8: fractional bits of the Q-format result, range 0..size.
REQ-003 SHALL have parameter depth, default 4: output FIFO entries, a power of two, at least 2.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 enable  in  1  the same enable driven to slow_multiplication; advances the valid-tracking pipeline.
REQ-007 in_valid  in  1  operands presented to the multiplier this cycle are real; sampled only when enable=1.
REQ-008 product  in  2*size  multiplier out, combinational from its last stage.
REQ-009 can_issue  out  1  upstream may assert in_valid with enable this cycle.
REQ-010 out_valid  out  1  FIFO head valid.
REQ-011 out_ready  in  1  consumer accepts head; transfer when out_valid&out_ready.
REQ-012 out_data  out  size  rounded, saturated result at FIFO head.
REQ-013 sat  out  1  head entry was saturated.
REQ-014 drop_err  out  1  sticky: a product was lost because the FIFO was full.

Function
REQ-015 SHALL keep a valid shift register vpipe[size-1:0], shifting in in_valid only on enable=1 edges, matching multiplier latency of size enabled edges.
REQ-016 SHALL register new_prod <= enable & vpipe[size-2] (vpipe[size-1] when size=1): high the cycle product holds a fresh result.
REQ-017 SHALL capture product exactly once, at the edge ending the new_prod cycle, regardless of enable in that cycle.
REQ-018 Result SHALL be r = (product + 2^(frac-1)) >> frac (round-half-up; no rounding term when frac=0), computed at 2*size+1 bits.
REQ-019 If r > 2^size-1, out_data SHALL be 2^size-1 with sat=1; otherwise r[size-1:0] with sat=0.
REQ-020 Rounding/saturation SHALL be combinational on product; {sat,out_data} is written to the FIFO at capture.
REQ-021 inflight SHALL equal popcount(vpipe) + new_prod, maintained as a counter.
REQ-022 can_issue SHALL be 1 iff count + inflight < depth, where count = FIFO occupancy; registered outputs not required.
REQ-023 Simultaneous capture and pop SHALL leave count unchanged with both operations done; pop on empty is ignored.
REQ-024 Capture when full without simultaneous pop SHALL discard the product, set drop_err, and leave the FIFO unchanged.
REQ-025 in_valid with enable=0 SHALL be ignored; in_valid while can_issue=0 is a protocol violation whose only consequence is REQ-024.
REQ-026 FIFO pointers SHALL wrap modulo depth; out_data/sat SHALL hold their value while out_valid=1 and out_ready=0.

Reset
REQ-027 While reset=0 at an edge: vpipe, new_prod, count, pointers and drop_err SHALL clear; out_valid=0, can_issue=1 in the following cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight and queued results; no capture occurs at the reset edge.
REQ-029 FIFO storage SHALL not require reset; out_data is don't-care while out_valid=0.

Structure
REQ-030 A shared header SHALL hold the default size/frac/depth constants used by the multiplier and the collector.
REQ-031 The FIFO SHALL be a sub-module sync_fifo (params width, depth; push, pop, full, empty, count); the rest is flat.
REQ-032 Target size SHALL be 120-400 lines RTL; no multiplier instance inside (the bench wires slow_multiplication alongside).

Verification (size=16, frac=8, depth=4, DUT paired with slow_multiplication)
REQ-033 Issue 0x0300*0x0200 once, enable held 1 -> out_valid rises 17 cycles after issue edge (16 stages + capture), out_data=0x0600, sat=0.
REQ-034 Issue 0x0001*0x0080 -> product 0x80 rounds up -> out_data=0x0001; 0x0001*0x007F -> 0x0000.
REQ-035 Issue 0xFFFF*0xFFFF -> out_data=0xFFFF, sat=1.
REQ-036 out_ready=0, issue on every can_issue -> exactly 4 accepted, can_issue=0 thereafter, drop_err=0; drain yields results in order.
REQ-037 Force in_valid past can_issue with FIFO full and out_ready=0 -> drop_err=1, FIFO contents unchanged.
REQ-038 Toggle enable randomly, plus reset asserted with 3 in flight -> each product captured once, correct order; after reset out_valid=0, can_issue=1, no stale outputs.
